// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator datapath timer blocks.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package calc_pkg;

  // Countdown timer control states.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } timer_state_t;

  // Width of the seconds value shown on the seven-segment display.
  localparam int TIME_W = 4;

  // Countdown length used while sitting in the calculation-error state.
  localparam int ERR_DEFAULT_SECS = 10;

  // A load value of zero selects the default countdown length.
  function automatic logic [TIME_W-1:0] load_secs(input logic [TIME_W-1:0] val,
                                                  input logic [TIME_W-1:0] dflt);
    return (val == '0) ? dflt : val;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the clock by PRESCALE, producing a tick on the last count of each period.
// Latency: tick is combinational from the registered count; first tick PRESCALE enabled cycles after clear.
// Backpressure: none; enable low freezes the count, clear restarts the period.
module tick_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int              CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = enable && (cnt_q == LAST);

  // Next count: clear wins, otherwise advance and wrap while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// Seconds countdown for the error display; pulses expired when the count reaches zero.
// Latency: all outputs registered; time_left valid the cycle after start, decrements every PRESCALE cycles.
// Backpressure: none; hold freezes prescaler and count, cancel aborts, start reloads.
module countdown_timer
  import calc_pkg::*;
#(
  parameter int CLK_FREQ_HZ  = 100_000_000,
  parameter int TICK_HZ      = 1,
  parameter int DEFAULT_SECS = ERR_DEFAULT_SECS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cancel,
  input  logic              hold,
  input  logic [TIME_W-1:0] load_val,
  output logic [TIME_W-1:0] time_left,
  output logic              running,
  output logic              sec_tick,
  output logic              expired
);

  localparam int PRESCALE = CLK_FREQ_HZ / TICK_HZ;
  localparam logic [TIME_W-1:0] DEFAULT_VAL = TIME_W'(DEFAULT_SECS);

  // Reject parameter sets that cannot be represented or divided.
  if (PRESCALE < 2) begin : g_bad_prescale
    $error("countdown_timer: CLK_FREQ_HZ / TICK_HZ must be at least 2");
  end
  if (DEFAULT_SECS > (2 ** TIME_W) - 1) begin : g_bad_default
    $error("countdown_timer: DEFAULT_SECS does not fit in time_left");
  end

  timer_state_t      state_q, state_d;
  logic [TIME_W-1:0] time_left_q, time_left_d;
  logic              running_q, running_d;
  logic              sec_tick_q, sec_tick_d;
  logic              expired_q, expired_d;

  logic ps_clear;
  logic ps_enable;
  logic ps_tick;

  // Any start or cancel restarts the one-second period; counting only in RUN and not held.
  assign ps_clear  = start || cancel;
  assign ps_enable = (state_q == RUN) && !hold;

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .clear  (ps_clear),
    .enable (ps_enable),
    .tick   (ps_tick)
  );

  // Next-state: cancel beats start beats hold beats the normal count.
  always_comb begin
    state_d     = state_q;
    time_left_d = time_left_q;
    running_d   = running_q;
    sec_tick_d  = 1'b0;
    expired_d   = 1'b0;

    if (cancel) begin
      // Cancel only matters mid-countdown; in IDLE it also swallows a same-cycle start.
      if (state_q == RUN) begin
        state_d     = IDLE;
        time_left_d = '0;
        running_d   = 1'b0;
      end
    end else if (start) begin
      state_d     = RUN;
      time_left_d = load_secs(load_val, DEFAULT_VAL);
      running_d   = 1'b1;
    end else if (ps_tick) begin
      sec_tick_d = 1'b1;
      if (time_left_q <= TIME_W'(1)) begin
        // Final second: land on zero and leave RUN, never wrap.
        state_d     = IDLE;
        time_left_d = '0;
        running_d   = 1'b0;
        expired_d   = 1'b1;
      end else begin
        time_left_d = time_left_q - 1'b1;
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      time_left_q <= '0;
      running_q   <= 1'b0;
      sec_tick_q  <= 1'b0;
      expired_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      time_left_q <= time_left_d;
      running_q   <= running_d;
      sec_tick_q  <= sec_tick_d;
      expired_q   <= expired_d;
    end
  end

  assign time_left = time_left_q;
  assign running   = running_q;
  assign sec_tick  = sec_tick_q;
  assign expired   = expired_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench: stimulus pushes model expectations, a monitor pops and compares each cycle.
// Latency: expectation for edge E is checked 1 time unit after E.
// Backpressure: n/a.
module tb_countdown_timer;

  localparam int P     = 4;   // CLK_FREQ_HZ=4, TICK_HZ=1
  localparam int DEF_S = 10;

  typedef struct packed {
    logic [3:0] tl;
    logic       run;
    logic       tick;
    logic       exp;
  } obs_t;

  logic       clk;
  logic       rst;
  logic       start;
  logic       cancel;
  logic       hold;
  logic [3:0] load_val;
  logic [3:0] time_left;
  logic       running;
  logic       sec_tick;
  logic       expired;

  countdown_timer #(
    .CLK_FREQ_HZ  (4),
    .TICK_HZ      (1),
    .DEFAULT_SECS (DEF_S)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cancel    (cancel),
    .hold      (hold),
    .load_val  (load_val),
    .time_left (time_left),
    .running   (running),
    .sec_tick  (sec_tick),
    .expired   (expired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  obs_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: seconds remaining plus active cycles elapsed since the last load.
  bit m_run;
  int m_secs;
  int m_elapsed;

  function automatic obs_t model_edge(input bit r, input bit s, input bit c,
                                      input bit h, input logic [3:0] lv);
    obs_t e;
    e.tick = 1'b0;
    e.exp  = 1'b0;
    if (r) begin
      m_run = 0; m_secs = 0; m_elapsed = 0;
    end else if (c) begin
      if (m_run) begin
        m_run = 0; m_secs = 0;
      end
    end else if (s) begin
      m_secs    = (lv == 4'd0) ? DEF_S : int'(lv);
      m_elapsed = 0;
      m_run     = 1;
    end else if (m_run && !h) begin
      m_elapsed++;
      if (m_elapsed % P == 0) begin
        m_secs--;
        e.tick = 1'b1;
        if (m_secs == 0) begin
          e.exp = 1'b1;
          m_run = 0;
        end
      end
    end
    e.tl  = 4'(m_secs);
    e.run = m_run;
    return e;
  endfunction

  // Drive one cycle of inputs on the falling edge and queue what the next rising edge must produce.
  task automatic step(input bit r, input bit s, input bit c, input bit h, input logic [3:0] lv);
    @(negedge clk);
    rst      = r;
    start    = s;
    cancel   = c;
    hold     = h;
    load_val = lv;
    exp_q.push_back(model_edge(r, s, c, h, lv));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 4'd0);
  endtask

  // Monitor: compare every presented output set against the oldest expectation.
  initial begin
    obs_t e;
    obs_t a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{tl: time_left, run: running, tick: sec_tick, exp: expired};
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL outputs t=%0t: got tl=%0d run=%b tick=%b exp=%b, want tl=%0d run=%b tick=%b exp=%b",
                   $time, a.tl, a.run, a.tick, a.exp, e.tl, e.run, e.tick, e.exp);
        end
      end
    end
  end

  initial begin
    // Reset state, checked at the first rising edge.
    rst = 1'b1; start = 1'b0; cancel = 1'b0; hold = 1'b0; load_val = 4'd0;
    exp_q.push_back(model_edge(1, 0, 0, 0, 4'd0));
    step(1, 0, 0, 0, 4'd0);
    step(1, 0, 0, 0, 4'd0);

    // Basic countdown from 3.
    idle(6);
    step(0, 1, 0, 0, 4'd3);
    idle(16);

    // Default load.
    step(0, 1, 0, 0, 4'd0);
    idle(44);

    // Cancel mid-run, then start and cancel together from IDLE.
    step(0, 1, 0, 0, 4'd5);
    idle(5);
    step(0, 0, 1, 0, 4'd0);
    idle(25);
    step(0, 1, 1, 0, 4'd7);
    idle(4);

    // Hold for 5 cycles starting 2 cycles after load.
    step(0, 1, 0, 0, 4'd2);
    step(0, 0, 0, 0, 4'd0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 4'd0);
    idle(10);

    // Restart mid-run with a shorter length.
    step(0, 1, 0, 0, 4'd4);
    idle(5);
    step(0, 1, 0, 0, 4'd2);
    idle(12);

    // Reset mid-run, then a fresh basic countdown.
    step(0, 1, 0, 0, 4'd4);
    idle(6);
    step(1, 0, 0, 0, 4'd0);
    idle(3);
    step(0, 1, 0, 0, 4'd3);
    idle(16);

    // Hold overlapping the final tick, and cancel/start during hold.
    step(0, 1, 0, 0, 4'd1);
    idle(3);
    step(0, 0, 0, 1, 4'd0);
    step(0, 0, 0, 1, 4'd0);
    step(0, 0, 0, 0, 4'd0);
    step(0, 1, 0, 1, 4'd6);
    step(0, 0, 0, 1, 4'd0);
    step(0, 0, 1, 1, 4'd0);
    idle(3);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 299) == 0,
           $urandom_range(0, 29) == 0,
           $urandom_range(0, 59) == 0,
           $urandom_range(0, 5) == 0,
           4'($urandom_range(0, 15)));
    end
    idle(2);

    @(posedge clk);
    #3;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
